neopix_chain: RTL

//  Parametrised WS2812/NeoPixel chain driver; successor to the fixed 3-pixel driver.
//  - Holds a NUM_PIX x 24-bit GRB frame buffer, written through a simple write port.
//  - Applies a global brightness scale to every output byte.
//  - On start, serialises one whole frame onto a single data pin, then holds the latch gap.
//  - Reports busy/done so top-level sequencers can pace animation frames.

---
 rtl/neopix_chain.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/neopix_chain.sv
// neopix_chain: parametrised WS2812/NeoPixel chain driver.
//   Holds a NUM_PIX x 24-bit GRB frame buffer and scales every byte by a global
//   brightness. On start it serialises one whole frame onto dout, MSB first,
//   pixel 0 first, and then holds the latch gap.
// Ports:
//   CLK        system clock
//   RST_N      asynchronous reset, active low
//   wr_en      frame-buffer write strobe
//   wr_addr    pixel index (>= NUM_PIX ignored)
//   wr_grb     pixel colour {G,R,B}
//   brightness global scale, 255 = unscaled, 0 = black
//   start      request one frame transmission (ignored while busy)
//   busy       frame in progress (bits or latch gap)
//   done       one-cycle pulse at the end of the latch gap
//   dout       serial data to the first pixel
module neopix_chain #(
  parameter  int NUM_PIX  = 3,
  parameter  int T0H_CYC  = 6,
  parameter  int T1H_CYC  = 13,
  parameter  int TBIT_CYC = 20,
  parameter  int TRES_CYC = 1280,
  localparam int AW       = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_grb,
  input  logic [7:0]    brightness,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          dout
);

  localparam int CW = $clog2(TRES_CYC + TBIT_CYC + 2);

  if (NUM_PIX < 1 || !(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC)) begin : g_bad_params
    $error("neopix_chain: illegal parameters (need NUM_PIX>=1, 0<T0H<T1H<TBIT)");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BIT_HI,
    S_BIT_LO,
    S_LATCH
  } state_t;

  // (byte * (b+1)) >> 8 ; b=255 is identity, b=0 gives 0.
  function automatic logic [7:0] scale8(input logic [7:0] v, input logic [7:0] b);
    logic [15:0] prod;
    prod = {8'd0, v} * ({8'd0, b} + 16'd1);
    return prod[15:8];
  endfunction

  function automatic logic [23:0] scale_px(input logic [23:0] p, input logic [7:0] b);
    return {scale8(p[23:16], b), scale8(p[15:8], b), scale8(p[7:0], b)};
  endfunction

  logic [23:0]   fb [NUM_PIX];

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [4:0]    bidx, bidx_d;
  logic [AW-1:0] pidx, pidx_d;
  logic [23:0]   sh, sh_d;
  logic [7:0]    bri_q, bri_d;
  logic          latch_end;

  logic [AW-1:0] nidx;
  logic [23:0]   pix0_raw, nxt_raw;
  logic [CW-1:0] hi_len, lo_len;
  logic          bit_last, pix_last;

  always_ff @(posedge CLK) begin
    if (wr_en && (32'(wr_addr) < NUM_PIX)) begin
      fb[wr_addr] <= wr_grb;
    end
  end

  // Pixels are read at their fetch time, so late writes to unsent pixels still land.
  assign nidx     = pidx + AW'(1);
  assign pix0_raw = fb[0];
  assign nxt_raw  = (32'(nidx) < NUM_PIX) ? fb[nidx] : 24'd0;

  assign hi_len   = sh[23] ? CW'(T1H_CYC) : CW'(T0H_CYC);
  assign lo_len   = CW'(TBIT_CYC) - hi_len;
  assign bit_last = (bidx == 5'd23);
  assign pix_last = (32'(pidx) == NUM_PIX - 1);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CW'(1);
    bidx_d    = bidx;
    pidx_d    = pidx;
    sh_d      = sh;
    bri_d     = bri_q;
    latch_end = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = S_FETCH;
          bri_d   = brightness;
        end
      end
      S_FETCH: begin
        state_d = S_BIT_HI;
        cnt_d   = '0;
        bidx_d  = '0;
        pidx_d  = '0;
        sh_d    = scale_px(pix0_raw, bri_q);
      end
      S_BIT_HI: begin
        if (cnt == hi_len - CW'(1)) begin
          state_d = S_BIT_LO;
          cnt_d   = '0;
        end
      end
      S_BIT_LO: begin
        if (cnt == lo_len - CW'(1)) begin
          cnt_d = '0;
          if (bit_last && pix_last) begin
            state_d = S_LATCH;
          end else if (bit_last) begin
            // next pixel enters the shifter with no gap between pixels
            state_d = S_BIT_HI;
            bidx_d  = '0;
            pidx_d  = nidx;
            sh_d    = scale_px(nxt_raw, bri_q);
          end else begin
            state_d = S_BIT_HI;
            bidx_d  = bidx + 5'd1;
            sh_d    = {sh[22:0], 1'b0};
          end
        end
      end
      S_LATCH: begin
        // one extra cycle here matches the one-cycle lag of the registered dout
        if (cnt == CW'(TRES_CYC)) begin
          latch_end = 1'b1;
          cnt_d     = '0;
          if (start) begin
            state_d = S_FETCH;
            bri_d   = brightness;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      cnt   <= '0;
      bidx  <= '0;
      pidx  <= '0;
      dout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      bidx  <= bidx_d;
      pidx  <= pidx_d;
      dout  <= (state == S_BIT_HI);
      busy  <= (state_d != S_IDLE);
      done  <= latch_end;
    end
  end

  always_ff @(posedge CLK) begin
    sh    <= sh_d;
    bri_q <= bri_d;
  end

endmodule
